// File: rtl/tree_deserializer.sv
// Serial-to-parallel receiver: hunts for SYNC_WORD at any bit offset, confirms
// alignment over LOCK_WORDS consecutive sync words, then emits one word per FROM bits.
module tree_deserializer #(
  parameter int unsigned     FROM       = 8,
  parameter int unsigned     LOGFROM    = 3,
  parameter logic [FROM-1:0] SYNC_WORD  = 8'hA5,
  parameter int unsigned     LOCK_WORDS = 3
) (
  input  logic            clk_i,
  input  logic            reset_ni,
  input  logic            data_i,
  input  logic            resync_i,
  output logic [FROM-1:0] data_o,
  output logic            valid_o,
  output logic            locked_o,
  output logic            align_err_o
);

  typedef enum logic [1:0] {
    ST_HUNT   = 2'd0,
    ST_VERIFY = 2'd1,
    ST_LOCKED = 2'd2
  } state_e;

  localparam logic [LOGFROM-1:0] CNT_LAST = LOGFROM'(FROM - 1);
  localparam logic [LOGFROM-1:0] CNT_ONE  = LOGFROM'(1);
  localparam logic [3:0]         LOCK_CNT = 4'(LOCK_WORDS);
  localparam bit                 ONE_WORD_LOCK = (LOCK_WORDS == 1);

  state_e             state_q, state_d;
  logic [FROM-1:0]    sr_q, sr_d;
  logic [LOGFROM-1:0] cnt_q, cnt_d;
  logic [3:0]         mcnt_q, mcnt_d;
  logic [FROM-1:0]    data_q, data_d;
  logic               valid_q, valid_d;
  logic               locked_q, locked_d;
  logic               err_q, err_d;

  logic               sync_hit;
  logic               boundary;
  logic [3:0]         mcnt_inc;

  // The newest bit enters at the MSB, so bit 0 ends up holding the first bit of a word.
  always_comb begin
    sr_d     = {data_i, sr_q[FROM-1:1]};
    sync_hit = (sr_d == SYNC_WORD);
    boundary = (cnt_q == CNT_LAST);
    mcnt_inc = mcnt_q + 4'd1;

    state_d  = state_q;
    cnt_d    = cnt_q;
    mcnt_d   = mcnt_q;
    data_d   = data_q;
    valid_d  = 1'b0;
    err_d    = 1'b0;

    if (resync_i) begin
      state_d = ST_HUNT;
      mcnt_d  = 4'd0;
    end else begin
      case (state_q)
        ST_HUNT: begin
          if (sync_hit) begin
            cnt_d   = '0;
            mcnt_d  = 4'd1;
            state_d = ONE_WORD_LOCK ? ST_LOCKED : ST_VERIFY;
          end
        end
        ST_VERIFY: begin
          cnt_d = cnt_q + CNT_ONE;
          if (boundary) begin
            if (sync_hit) begin
              mcnt_d = mcnt_inc;
              if (mcnt_inc == LOCK_CNT) begin
                state_d = ST_LOCKED;
              end
            end else begin
              // A failed boundary drops straight back to hunting; this cycle is not re-searched.
              err_d   = 1'b1;
              mcnt_d  = 4'd0;
              state_d = ST_HUNT;
            end
          end
        end
        ST_LOCKED: begin
          cnt_d = cnt_q + CNT_ONE;
          if (boundary) begin
            data_d  = sr_d;
            valid_d = 1'b1;
          end
        end
        default: begin
          state_d = ST_HUNT;
        end
      endcase
    end

    locked_d = (state_d == ST_LOCKED);
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q  <= ST_HUNT;
      sr_q     <= '0;
      cnt_q    <= '0;
      mcnt_q   <= 4'd0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      locked_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      sr_q     <= sr_d;
      cnt_q    <= cnt_d;
      mcnt_q   <= mcnt_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      locked_q <= locked_d;
      err_q    <= err_d;
    end
  end

  assign data_o      = data_q;
  assign valid_o     = valid_q;
  assign locked_o    = locked_q;
  assign align_err_o = err_q;

endmodule

// File: tb/tb_tree_deserializer.sv
// Bench for tree_deserializer: an 8-bit/3-word-lock instance through directed scenarios
// plus random payload, and a 16-bit/1-word-lock instance with random offset and payload.
module tb_tree_deserializer;

  logic        clk;
  logic        reset_na, data_a, resync_a;
  logic [7:0]  data_a_o;
  logic        valid_a, locked_a, err_a;
  logic        reset_nb, data_b, resync_b;
  logic [15:0] data_b_o;
  logic        valid_b, locked_b, err_b;

  tree_deserializer #(.FROM(8), .LOGFROM(3), .SYNC_WORD(8'hA5), .LOCK_WORDS(3)) u_dut_a (
    .clk_i(clk), .reset_ni(reset_na), .data_i(data_a), .resync_i(resync_a),
    .data_o(data_a_o), .valid_o(valid_a), .locked_o(locked_a), .align_err_o(err_a)
  );

  tree_deserializer #(.FROM(16), .LOGFROM(4), .SYNC_WORD(16'hC3A5), .LOCK_WORDS(1)) u_dut_b (
    .clk_i(clk), .reset_ni(reset_nb), .data_i(data_b), .resync_i(resync_b),
    .data_o(data_b_o), .valid_o(valid_b), .locked_o(locked_b), .align_err_o(err_b)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int tick_no  = 0;
  int err_cnt_a = 0;
  bit run_a = 0;
  bit run_b = 0;
  logic [15:0] exp_qa[$];
  logic [15:0] exp_qb[$];
  int valid_t[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (tick %0d)", tag, got, exp, tick_no);
    end
  endtask

  // Reference model: keeps the raw bit history and an alignment time; word boundaries
  // are those cycles a whole multiple of the word width after the aligning sync word.
  logic [63:0] m_hist[2];
  int          m_mode[2];   // 0 hunting, 1 confirming, 2 locked
  int          m_t[2];
  int          m_align[2];
  int          m_seen[2];
  logic [15:0] m_data[2];
  logic        m_valid[2];
  logic        m_err[2];
  logic        m_locked[2];

  task automatic model_reset(input int k);
    m_hist[k] = '0; m_mode[k] = 0; m_t[k] = 0; m_align[k] = 0; m_seen[k] = 0;
    m_data[k] = '0; m_valid[k] = 0; m_err[k] = 0; m_locked[k] = 0;
  endtask

  task automatic model_step(input int k, input logic b, input logic r);
    int f, lw;
    logic [15:0] sw, win;
    f  = (k == 0) ? 8 : 16;
    lw = (k == 0) ? 3 : 1;
    sw = (k == 0) ? 16'h00A5 : 16'hC3A5;
    m_hist[k] = {m_hist[k][62:0], b};
    m_t[k]++;
    win = '0;
    for (int i = 0; i < f; i++) win[i] = m_hist[k][f-1-i];
    m_valid[k] = 1'b0;
    m_err[k]   = 1'b0;
    if (r) begin
      m_mode[k] = 0;
    end else if (m_mode[k] == 0) begin
      if (win == sw) begin
        m_align[k] = m_t[k];
        m_seen[k]  = 1;
        m_mode[k]  = (lw == 1) ? 2 : 1;
      end
    end else if (((m_t[k] - m_align[k]) % f) == 0) begin
      if (m_mode[k] == 1) begin
        if (win == sw) begin
          m_seen[k]++;
          if (m_seen[k] == lw) m_mode[k] = 2;
        end else begin
          m_err[k]  = 1'b1;
          m_mode[k] = 0;
        end
      end else begin
        m_data[k]  = win;
        m_valid[k] = 1'b1;
      end
    end
    m_locked[k] = (m_mode[k] == 2);
  endtask

  // driver: one serial bit per instance per clock
  task automatic tick(input logic da, input logic ra, input logic db, input logic rb);
    data_a = da; resync_a = ra; data_b = db; resync_b = rb;
    @(posedge clk);
    #1;
    tick_no++;
    if (run_a) begin
      model_step(0, da, ra);
      check_eq("a_valid", valid_a, m_valid[0]);
      check_eq("a_err", err_a, m_err[0]);
      check_eq("a_locked", locked_a, m_locked[0]);
      check_eq("a_data", {24'h0, data_a_o}, {16'h0, m_data[0]});
      if (err_a) err_cnt_a++;
      if (valid_a) begin
        valid_t.push_back(tick_no);
        if (exp_qa.size() == 0) check_eq("a_unexpected_valid", valid_a, 1'b0);
        else check_eq("a_scoreboard", {24'h0, data_a_o}, {16'h0, exp_qa.pop_front()});
      end
    end
    if (run_b) begin
      model_step(1, db, rb);
      check_eq("b_valid", valid_b, m_valid[1]);
      check_eq("b_err", err_b, m_err[1]);
      check_eq("b_locked", locked_b, m_locked[1]);
      check_eq("b_data", {16'h0, data_b_o}, {16'h0, m_data[1]});
      if (valid_b) begin
        if (exp_qb.size() == 0) check_eq("b_unexpected_valid", valid_b, 1'b0);
        else check_eq("b_scoreboard", {16'h0, data_b_o}, {16'h0, exp_qb.pop_front()});
      end
    end
  endtask

  task automatic send_a(input logic [7:0] w, input int rs_at);
    for (int i = 0; i < 8; i++) tick(w[i], (i == rs_at), 1'b0, 1'b0);
  endtask

  task automatic send_b(input logic [15:0] w);
    for (int i = 0; i < 16; i++) tick(1'b0, 1'b0, w[i], 1'b0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int errs_before;
    int tries;
    bit ok;
    logic bits[$];
    logic [15:0] w16;
    logic [15:0] sw_b;
    logic [7:0]  w8;

    reset_na = 1'b0; reset_nb = 1'b0;
    data_a = 1'b0; resync_a = 1'b0; data_b = 1'b0; resync_b = 1'b0;
    model_reset(0);
    model_reset(1);
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_a_data", {24'h0, data_a_o}, 32'h0);
    check_eq("rst_a_valid", valid_a, 1'b0);
    check_eq("rst_a_locked", locked_a, 1'b0);
    check_eq("rst_a_err", err_a, 1'b0);
    check_eq("rst_b_data", {16'h0, data_b_o}, 32'h0);
    check_eq("rst_b_locked", locked_b, 1'b0);
    reset_na = 1'b1;
    run_a = 1;

    // reset then lock, two payload words
    repeat (3) tick(1'b0, 1'b0, 1'b0, 1'b0);
    send_a(8'hA5, -1);
    send_a(8'hA5, -1);
    check_eq("s1_not_locked_yet", locked_a, 1'b0);
    send_a(8'hA5, -1);
    check_eq("s1_lock_rise", locked_a, 1'b1);
    exp_qa.push_back(16'h3C); send_a(8'h3C, -1);
    exp_qa.push_back(16'hF0); send_a(8'hF0, -1);
    check_eq("s1_valid_count", valid_t.size(), 2);
    if (valid_t.size() == 2) check_eq("s1_valid_gap", valid_t[1] - valid_t[0], 8);

    // verify failure then relock
    tick(1'b0, 1'b1, 1'b0, 1'b0);
    check_eq("s2_unlocked", locked_a, 1'b0);
    errs_before = err_cnt_a;
    send_a(8'hA5, -1);
    send_a(8'hA5, -1);
    send_a(8'h5A, -1);
    check_eq("s2_err_once", err_cnt_a - errs_before, 1);
    check_eq("s2_still_unlocked", locked_a, 1'b0);
    repeat (3) send_a(8'hA5, -1);
    check_eq("s2_relock", locked_a, 1'b1);

    // payload equal to sync, then random payload
    exp_qa.push_back(16'hA5); send_a(8'hA5, -1);
    check_eq("s3_locked_after_sync_payload", locked_a, 1'b1);
    exp_qa.push_back(16'h77); send_a(8'h77, -1);
    for (int n = 0; n < 6; n++) begin
      w8 = 8'($urandom_range(0, 255));
      exp_qa.push_back({8'h0, w8});
      send_a(w8, -1);
    end
    check_eq("s3_no_err", err_cnt_a - errs_before, 1);

    // resync three bits into a payload word
    exp_qa.push_back(16'h77); send_a(8'h77, -1);
    for (int i = 0; i < 8; i++) begin
      tick(w16_bit(8'h96, i), (i == 3), 1'b0, 1'b0);
      if (i == 3) check_eq("s4_lock_drop", locked_a, 1'b0);
    end
    repeat (3) send_a(8'hA5, -1);
    check_eq("s4_relock", locked_a, 1'b1);
    exp_qa.push_back(16'hC8); send_a(8'hC8, -1);

    // asynchronous reset between edges while locked
    for (int i = 0; i < 3; i++) tick(w16_bit(8'h5B, i), 1'b0, 1'b0, 1'b0);
    #3;
    reset_na = 1'b0;
    #1;
    check_eq("s5_async_data", {24'h0, data_a_o}, 32'h0);
    check_eq("s5_async_valid", valid_a, 1'b0);
    check_eq("s5_async_locked", locked_a, 1'b0);
    check_eq("s5_async_err", err_a, 1'b0);
    model_reset(0);
    @(posedge clk);
    @(posedge clk);
    #1;
    check_eq("s5_held_locked", locked_a, 1'b0);
    reset_na = 1'b1;
    repeat (5) tick(1'b0, 1'b0, 1'b0, 1'b0);
    repeat (2) send_a(8'hA5, -1);
    send_a(8'hA5, -1);
    check_eq("s5_relock", locked_a, 1'b1);
    exp_qa.push_back(16'h42); send_a(8'h42, -1);
    tick(1'b0, 1'b1, 1'b0, 1'b0);

    // 16-bit instance: random offset, lock on first sync word, random payload
    sw_b = 16'hC3A5;
    tries = 0;
    do begin
      ok = 1;
      tries++;
      bits.delete();
      for (int i = 0; i < 16; i++) bits.push_back(1'b0);
      for (int i = 0; i < int'($urandom_range(0, 40)); i++) bits.push_back(1'($urandom_range(0, 1)));
      for (int i = 0; i < 16; i++) bits.push_back(sw_b[i]);
      for (int e = 15; e < bits.size() - 1; e++) begin
        w16 = '0;
        for (int i = 0; i < 16; i++) w16[i] = bits[e-15+i];
        if (w16 == sw_b) ok = 0;
      end
    end while (!ok && tries < 50);
    reset_nb = 1'b1;
    model_reset(1);
    run_b = 1;
    for (int i = 16; i < bits.size(); i++) tick(1'b0, 1'b0, bits[i], 1'b0);
    check_eq("b_lock_first", locked_b, 1'b1);
    for (int n = 0; n < 20; n++) begin
      w16 = 16'($urandom_range(0, 65535));
      exp_qb.push_back(w16);
      send_b(w16);
    end
    check_eq("b_no_err", err_b, 1'b0);

    check_eq("a_scoreboard_drained", exp_qa.size(), 0);
    check_eq("b_scoreboard_drained", exp_qb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  function automatic logic w16_bit(input logic [7:0] w, input int i);
    return w[i];
  endfunction

endmodule

// File: doc/tree_deserializer.md
# tree_deserializer

Single-clock serial-to-parallel receiver that rebuilds `FROM`-bit words from the 1-bit stream produced by the tree-structured serializer. It hunts for a programmable sync word, confirms word alignment over several consecutive sync words, and then emits one aligned parallel word every `FROM` clock cycles with a one-cycle valid strobe. It sits on the receive side of the serial link, clocked by the bit clock, and feeds downstream parallel logic.

## Interface
- `FROM`, 8: parallel word width in bits; power of two, at least 4.
- `LOGFROM`, 3: log2(`FROM`); width of the bit counter.
- `SYNC_WORD`, 8'hA5: `FROM`-bit alignment pattern, transmitted LSB first.
- `LOCK_WORDS`, 3: consecutive aligned sync words required for lock, including the first match; range 1..15.

- `clk_i`  in  1  bit clock; one serial bit per rising edge.
- `reset_ni`  in  1  asynchronous, active-low reset.
- `data_i`  in  1  serial data, LSB of each word first.
- `resync_i`  in  1  synchronous request to drop lock and re-hunt; level-sensitive.
- `data_o`  out  `FROM`  last completed word; bit 0 is the first bit received.
- `valid_o`  out  1  one-cycle pulse when `data_o` is updated in LOCKED.
- `locked_o`  out  1  high while in LOCKED.
- `align_err_o`  out  1  one-cycle pulse on a sync mismatch in VERIFY.

## Operation
- Shift register: `sr_next = {data_i, sr[FROM-1:1]}`. `sr <= sr_next` every cycle in every state.
- Bit counter `cnt` (`LOGFROM` bits) wraps from `FROM-1` to 0. A word boundary is a cycle where `cnt == FROM-1`.
- Match counter `mcnt` is 4 bits wide.
- States:
  - HUNT (reset state).
    - When `sr_next == SYNC_WORD`: `cnt <= 0`, `mcnt <= 1`.
    - If `LOCK_WORDS == 1`, go to LOCKED; otherwise go to VERIFY.
    - With no match, `cnt` is don't-care and held.
  - VERIFY. `cnt` increments each cycle. At each word boundary:
    - If `sr_next == SYNC_WORD`: `mcnt <= mcnt+1`. When `mcnt+1 == LOCK_WORDS`, go to LOCKED.
    - Otherwise: pulse `align_err_o`, return to HUNT. The same cycle is not re-checked for a match.
  - LOCKED. `cnt` increments each cycle. At each word boundary: `data_o <= sr_next`, `valid_o <= 1`.
    - Payload content, including words equal to `SYNC_WORD`, never affects state.
- `resync_i` high in any state sends the block to HUNT on the next edge and clears `mcnt`.
  - It overrides every other transition in that cycle.
  - It suppresses `valid_o` and `align_err_o` for that edge.
- `data_o` holds its last value outside valid cycles and is never cleared except by reset.
- Reset values, applied asynchronously while `reset_ni == 0`:
  - `sr`, `cnt`, `mcnt` = 0.
  - State = HUNT.
  - `data_o` = 0, `valid_o` = 0, `locked_o` = 0, `align_err_o` = 0.
- Reset asserted mid-word discards the partial word. No `valid_o` is produced for it.

## Timing
- All outputs are registered.
- Latency: the last bit of a word is sampled at edge N; `data_o` and `valid_o` are visible after edge N. The first bit of that word was sampled at edge N-(FROM-1).
- In LOCKED, `valid_o` pulses exactly every `FROM` cycles, one cycle wide.
- Sync matching in HUNT:
  - Matching is checked every cycle, so any bit offset aligns.
  - A match on the very first `FROM` bits after reset is allowed, because `sr` resets to 0 and `SYNC_WORD` is nonzero by convention.
- `locked_o` rises on the edge entering LOCKED.
- The first payload `valid_o` comes `FROM` cycles after the boundary of the last sync word.
- `locked_o` falls on the edge after `resync_i` is sampled high.
- The upstream serializer's output register adds one bit of skew. The HUNT search absorbs this; the block has no fixed-phase assumption.

## Test plan
- Reset then lock:
  - Stimulus: release `reset_ni`, send 3 bits of 0, then 0xA5, 0xA5, 0xA5 LSB first, then 0x3C, 0xF0.
  - Required: `locked_o` rises at the end of the third 0xA5. `valid_o` pulses twice, 8 cycles apart, with `data_o` = 0x3C then 0xF0.
- Verify failure:
  - Stimulus: 0xA5, 0xA5, 0x5A.
  - Required: `align_err_o` pulses once at the 0x5A boundary, the block returns to HUNT, and `locked_o` stays 0. A following 0xA5×3 then locks.
- Payload equal to sync:
  - Stimulus: while LOCKED, send 0xA5 as payload.
  - Required: `data_o` = 0xA5 with `valid_o`, `locked_o` stays 1, no `align_err_o`.
- Resync mid-word:
  - Stimulus: assert `resync_i` for 1 cycle 3 bits into a payload word.
  - Required: `locked_o` falls on the next edge, no `valid_o` for the partial word, and a re-lock occurs after the next 3 sync words.
- Async reset mid-operation:
  - Stimulus: drop `reset_ni` between edges while LOCKED.
  - Required: all outputs are 0 immediately, without waiting for a clock edge, and stay 0 until the relock sequence completes.
- Parameter sweep:
  - Stimulus: `FROM`=16, `LOGFROM`=4, `SYNC_WORD`=16'hC3A5, `LOCK_WORDS`=1, random bit offset, random payload.
  - Required: lock on the first sync word, and every payload word matches a scoreboard.
